// File: rtl/lfsr_prbs_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lfsr_prbs_gen_if                                                 |
// | Brief   : Step/load/seed bus of the PRBS generator; optional error-inject  |
// |           line under LFSR_ERR_INJECT_EN.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lfsr_prbs_gen_if #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned OUT_W = 1
);
    logic             i_valid;
    logic             i_load;
    logic [WIDTH-1:0] i_seed;
`ifdef LFSR_ERR_INJECT_EN
    logic             i_err_inject;
`endif
    logic [OUT_W-1:0] o_data;
    logic             o_valid;
    logic             o_wrap;
    logic             o_lockup;

`ifdef LFSR_ERR_INJECT_EN
    modport master (
        output i_valid, i_load, i_seed, i_err_inject,
        input  o_data, o_valid, o_wrap, o_lockup
    );
    modport slave (
        input  i_valid, i_load, i_seed, i_err_inject,
        output o_data, o_valid, o_wrap, o_lockup
    );
`else
    modport master (
        output i_valid, i_load, i_seed,
        input  o_data, o_valid, o_wrap, o_lockup
    );
    modport slave (
        input  i_valid, i_load, i_seed,
        output o_data, o_valid, o_wrap, o_lockup
    );
`endif
endinterface
`default_nettype wire

// File: rtl/lfsr_prbs_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lfsr_prbs_gen                                                    |
// | Brief   : Fibonacci LFSR PRBS generator, OUT_W bits per step, runtime seed,|
// |           wrap pulse, all-zero recovery. Macro LFSR_ERR_INJECT_EN adds     |
// |           single-bit error injection on o_data[0].                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lfsr_prbs_gen #(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'h60,
    parameter logic [WIDTH-1:0] SEED  = 7'h7F,
    parameter int unsigned      OUT_W = 1
) (
    input  wire logic      i_clk,
    input  wire logic      i_reset,
    lfsr_prbs_gen_if.slave bus
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] active_seed_q, active_seed_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] w_walk;
    logic [WIDTH-1:0] w_step_state;
    logic [OUT_W-1:0] w_step_bits;
    logic [OUT_W-1:0] w_flip;
    logic             w_err;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load_state;
    logic [WIDTH:0]   w_cnt_inc;
    logic             w_hit;

    // OUT_W shifts unrolled; the first bit shifted out lands in the MSB.
    always_comb begin
        w_walk      = state_q;
        w_step_bits = '0;
        for (int j = 0; j < int'(OUT_W); j++) begin
            w_step_bits[OUT_W-1-j] = w_walk[WIDTH-1];
            w_walk = {w_walk[WIDTH-2:0], ^(w_walk & TAPS)};
        end
    end

    // Degenerate TAPS can collapse to zero; fall back to SEED so the register never locks.
    assign w_step_state = (w_walk == '0) ? SEED : w_walk;

    assign w_seed_zero  = (bus.i_seed == '0);
    assign w_load_state = w_seed_zero ? SEED : bus.i_seed;
    assign w_cnt_inc    = cnt_q + 1'b1;
    assign w_hit        = (w_step_state == active_seed_q) && (w_cnt_inc != '0);

`ifdef LFSR_ERR_INJECT_EN
    assign w_err = bus.i_err_inject;
`else
    assign w_err = 1'b0;
`endif

    always_comb begin
        w_flip    = '0;
        w_flip[0] = w_err;
    end

    always_comb begin
        state_d       = state_q;
        active_seed_d = active_seed_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        wrap_d        = 1'b0;
        lockup_d      = 1'b0;
        if (bus.i_load) begin
            state_d       = w_load_state;
            active_seed_d = w_load_state;
            cnt_d         = '0;
            lockup_d      = w_seed_zero;
        end else if (bus.i_valid) begin
            state_d = w_step_state;
            data_d  = w_step_bits ^ w_flip;
            valid_d = 1'b1;
            wrap_d  = w_hit;
            cnt_d   = w_hit ? '0 : w_cnt_inc;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= SEED;
            active_seed_q <= SEED;
            cnt_q         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            wrap_q        <= 1'b0;
            lockup_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_seed_q <= active_seed_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            wrap_q        <= wrap_d;
            lockup_q      <= lockup_d;
        end
    end

    assign bus.o_data   = data_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_wrap   = wrap_q;
    assign bus.o_lockup = lockup_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lfsr_prbs_gen                                                 |
// | Brief   : Directed bench for lfsr_prbs_gen (OUT_W=1 and OUT_W=8 instances).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lfsr_prbs_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_prbs_gen_if #(.WIDTH(7), .OUT_W(1)) bus1 ();
    lfsr_prbs_gen_if #(.WIDTH(7), .OUT_W(8)) bus8 ();

    lfsr_prbs_gen #(.WIDTH(7), .TAPS(7'h60), .SEED(7'h7F), .OUT_W(1)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1)
    );

    lfsr_prbs_gen #(.WIDTH(7), .TAPS(7'h60), .SEED(7'h7F), .OUT_W(8)) dut8 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference PRBS7: x^7 + x^6 + 1, output bit is the MSB before the shift.
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] m;
        logic [6:0] m8;
        logic [7:0] w;
        logic       eb;
        logic       last_bit;
        logic [6:0] pat;

        rst          = 1'b1;
        bus1.i_valid = 1'b0;
        bus1.i_load  = 1'b0;
        bus1.i_seed  = '0;
        bus8.i_valid = 1'b0;
        bus8.i_load  = 1'b0;
        bus8.i_seed  = '0;
`ifdef LFSR_ERR_INJECT_EN
        bus1.i_err_inject = 1'b0;
        bus8.i_err_inject = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",   32'(bus1.o_data),   0);
        chk("rst_valid",  32'(bus1.o_valid),  0);
        chk("rst_wrap",   32'(bus1.o_wrap),   0);
        chk("rst_lockup", 32'(bus1.o_lockup), 0);
        chk("rst_data8",  32'(bus8.o_data),   0);
        rst = 1'b0;
        tick();
        chk("idle_valid", 32'(bus1.o_valid), 0);

        // Continuous stepping on both widths
        m  = 7'h7F;
        m8 = 7'h7F;
        bus1.i_valid = 1'b1;
        bus8.i_valid = 1'b1;
        last_bit = 1'b0;
        for (int k = 1; k <= 254; k++) begin
            tick();
            eb = m[6];
            m  = prbs7_next(m);
            last_bit = eb;
            for (int b = 0; b < 8; b++) begin
                w[7-b] = m8[6];
                m8 = prbs7_next(m8);
            end
            chk("s1_valid",  32'(bus1.o_valid),  1);
            chk("s1_data",   32'(bus1.o_data),   32'(eb));
            chk("s1_wrap",   32'(bus1.o_wrap),   32'((k == 127) || (k == 254)));
            chk("s1_lockup", 32'(bus1.o_lockup), 0);
            if (k <= 7) chk("s1_first7", 32'(bus1.o_data), 1);
            if (k == 8) chk("s1_eighth", 32'(bus1.o_data), 0);
            chk("s3_valid8", 32'(bus8.o_valid), 1);
            chk("s3_data8",  32'(bus8.o_data),  32'(w));
            chk("s3_wrap8",  32'(bus8.o_wrap),  32'((k == 127) || (k == 254)));
            if (k == 1) chk("s3_first_word", 32'(bus8.o_data), 32'h0FE);
        end
        bus8.i_valid = 1'b0;

        // Idle gap: data holds
        bus1.i_valid = 1'b0;
        tick();
        chk("gap_valid", 32'(bus1.o_valid), 0);
        chk("gap_hold",  32'(bus1.o_data),  32'(last_bit));
        chk("gap_valid8", 32'(bus8.o_valid), 0);
        chk("gap_hold8",  32'(bus8.o_data),  32'(w));

        // Load 7'h01 with a simultaneous step request; the step is dropped
        bus1.i_valid = 1'b1;
        bus1.i_load  = 1'b1;
        bus1.i_seed  = 7'h01;
        tick();
        chk("s4_valid",  32'(bus1.o_valid),  0);
        chk("s4_wrap",   32'(bus1.o_wrap),   0);
        chk("s4_lockup", 32'(bus1.o_lockup), 0);
        chk("s4_hold",   32'(bus1.o_data),   32'(last_bit));
        bus1.i_load = 1'b0;
        m   = 7'h01;
        pat = 7'b0000001;
        for (int k = 1; k <= 27; k++) begin
            tick();
            eb = m[6];
            m  = prbs7_next(m);
            if (k <= 7) chk("s4_first7", 32'(bus1.o_data), 32'(pat[7-k]));
            chk("s4_data",  32'(bus1.o_data),  32'(eb));
            chk("s4_valid_run", 32'(bus1.o_valid), 1);
        end

        // Zero seed triggers lock-up recovery to SEED
        bus1.i_load = 1'b1;
        bus1.i_seed = 7'h00;
        tick();
        chk("s5_lockup", 32'(bus1.o_lockup), 1);
        chk("s5_valid",  32'(bus1.o_valid),  0);
        bus1.i_load = 1'b0;
        m = 7'h7F;
        for (int k = 1; k <= 300; k++) begin
            tick();
            eb = m[6];
            m  = prbs7_next(m);
            chk("s5_data",    32'(bus1.o_data),   32'(eb));
            chk("s5_lockup0", 32'(bus1.o_lockup), 0);
            chk("s5_wrap",    32'(bus1.o_wrap),   32'((k == 127) || (k == 254)));
            chk("s5_nonzero", 32'(dut.state_q != 7'h00), 1);
        end

        // Reset mid-sequence with a load pending: load is lost
        bus1.i_load = 1'b1;
        bus1.i_seed = 7'h05;
        rst = 1'b1;
        tick();
        chk("mrst_valid", 32'(bus1.o_valid), 0);
        chk("mrst_data",  32'(bus1.o_data),  0);
        rst = 1'b0;
        bus1.i_load = 1'b0;
        m = 7'h7F;
        for (int k = 1; k <= 10; k++) begin
            tick();
            eb = m[6];
            m  = prbs7_next(m);
            chk("mrst_seq", 32'(bus1.o_data), 32'(eb));
        end

`ifdef LFSR_ERR_INJECT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m = 7'h7F;
        for (int k = 1; k <= 20; k++) begin
            bus1.i_err_inject = (k == 10);
            tick();
            eb = m[6] ^ (k == 10);
            m  = prbs7_next(m);
            chk("s6_data", 32'(bus1.o_data), 32'(eb));
        end
        bus1.i_err_inject = 1'b0;
`endif

        bus1.i_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_prbs_gen.md
Name: lfsr_prbs_gen

Overview:
Parametrised successor of the single-bit lfsr generator. Fibonacci LFSR with configurable width, polynomial, seed and output bits per step. Adds:
- runtime seed load
- registered valid output
- sequence-wrap indication
- all-zero lock-up recovery

Sits in the test-pattern/scrambler path; feeds modulators, channel models and BER checkers.

Parameters:
- WIDTH, 7: LFSR state width (min 3, max 32).
- TAPS, 7'h60: feedback polynomial mask (WIDTH bits). A set bit k puts state[k] into the feedback XOR. Default = x^7+x^6+1 (PRBS7).
- SEED, 7'h7F: reset and recovery state (WIDTH bits). Must be nonzero.
- OUT_W, 1: bits produced per accepted step (1..WIDTH).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  step request; each cycle high advances the LFSR by OUT_W shifts.
- i_load  in  1  load i_seed into state this cycle.
- i_seed  in  WIDTH  runtime seed value.
- o_data  out  OUT_W  generated bits; MSB = first bit in time.
- o_valid  out  1  o_data is fresh this cycle.
- o_wrap  out  1  one-cycle pulse when the state returns to the active seed.
- o_lockup  out  1  one-cycle pulse when an all-zero seed was replaced by SEED.

Behaviour:
- Reset (async assert, sync release):
  - state = SEED, active_seed = SEED.
  - o_data = 0, o_valid = 0, o_wrap = 0, o_lockup = 0.
- Single shift:
  - out_bit = state[WIDTH-1].
  - fb = XOR of state[k] for every k with TAPS[k] = 1.
  - state <= {state[WIDTH-2:0], fb}.
- Step:
  - OUT_W shifts are computed combinationally in one cycle (unrolled).
  - Bit produced by shift j (j = 0 first) goes to o_data[OUT_W-1-j].
- Latency:
  - i_valid high at edge N → o_data/o_valid updated at edge N+1 (1 cycle).
  - o_valid = registered i_valid gated by no-load.
  - o_data holds its last value while o_valid = 0.
- Load:
  - i_load high at an edge sets state <= i_seed and active_seed <= i_seed.
  - o_valid = 0 next cycle.
  - i_load has priority over a simultaneous i_valid; that step is dropped, not deferred.
- Lock-up recovery:
  - If i_seed == 0 when loaded, state and active_seed <= SEED instead.
  - o_lockup pulses 1 cycle, at the same time o_valid goes 0.
  - The state register can never hold all-zero.
- Wrap:
  - o_wrap is asserted with o_valid when the post-step state equals active_seed.
  - Example: for PRBS7, OUT_W = 1, this is every 127 steps.
  - For general OUT_W, the period in steps is P/gcd(P, OUT_W).
  - No pulse occurs on load.
- Step counter: internal, WIDTH+1 bits. Counts steps since the last load/reset and clears on wrap. Its only purpose is to qualify o_wrap, which is suppressed when the count is 0.
- Continuous i_valid: one step per cycle, no bubbles.
- Reset mid-sequence: immediate return to the reset state. A load pending in the same cycle is lost.
- Non-maximal TAPS: generated without error. o_wrap still follows the rule above.

Optional Feature:
Macro LFSR_ERR_INJECT_EN.
- Defined:
  - Adds input port i_err_inject (1 bit).
  - When i_err_inject and i_valid are both high, the step's o_data[0] is inverted on output.
  - LFSR state, the wrap logic and subsequent steps are unaffected.
  - Ignored during a load cycle.
- Undefined: the port is absent and o_data is always the pure sequence.

Test Plan:
1. Reset, then i_valid = 1 continuously (defaults) → o_valid rises 1 cycle after i_valid. o_data = 1 for the first 7 outputs, then 0. Sequence matches a PRBS7 software model for 254 bits.
2. Defaults, i_valid continuous → o_wrap pulses at output 127 and output 254 only. o_lockup stays 0.
3. OUT_W = 8, SEED = 7'h7F → first o_data = 8'hFE. Bitstream equals the OUT_W = 1 stream packed MSB-first. o_wrap pulses after 127 words.
4. Load i_seed = 7'h01 with i_valid = 1 in the same cycle → next cycle o_valid = 0. Following outputs start from state 7'h01 (first bits 0,0,0,0,0,0,1). The dropped step is not replayed.
5. Load i_seed = 0 → o_lockup pulses once. Stream restarts identical to scenario 1. The state register is never zero across 300 steps.
6. LFSR_ERR_INJECT_EN defined, i_err_inject pulsed on step 10 → only output 10 differs from the model (bit 0 flipped). Outputs 11 onward match the model.
